// File: rtl/spi_display_pkg.sv
// rtl/spi_display_pkg.sv - shared types for the display-link receiver
package spi_display_pkg;
  localparam int DISP_DATA_W = 8;

  typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_e;

  typedef struct packed {
    logic                   is_data;
    logic [DISP_DATA_W-1:0] data;
  } disp_byte_t;
endpackage

// File: rtl/spi_rx_sync.sv
// rtl/spi_rx_sync.sv - single-bit multi-flop synchroniser with selectable reset value
module spi_rx_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);
  logic [SYNC_STAGES-1:0] ff_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ff_q <= {SYNC_STAGES{RESET_VAL}};
    else       ff_q <= {ff_q[SYNC_STAGES-2:0], d_i};
  end

  assign q_o = ff_q[SYNC_STAGES-1];
endmodule

// File: rtl/spi_display_rx.sv
// rtl/spi_display_rx.sv - display-link SPI mode-0 receiver; SPI_DISPLAY_RX_FIFO_EN selects FIFO output stage
module spi_display_rx
  import spi_display_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = DISP_DATA_W,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              SCLK,
  input  logic              SDIN,
  input  logic              DnC,
  input  logic              nCS,
  output logic [DATA_W-1:0] RxData,
  output logic              RxIsData,
  output logic              RxValid,
  input  logic              RxReady,
  input  logic              ClearStatus,
  output logic              Overflow,
  output logic              FrameError,
  output logic              Busy
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic s_sclk, s_sdin, s_dnc, s_ncs;

  spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i(Clock), .rst_i(Reset), .d_i(SCLK), .q_o(s_sclk));
  spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdin (
    .clk_i(Clock), .rst_i(Reset), .d_i(SDIN), .q_o(s_sdin));
  spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_dnc (
    .clk_i(Clock), .rst_i(Reset), .d_i(DnC), .q_o(s_dnc));
  spi_rx_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk_i(Clock), .rst_i(Reset), .d_i(nCS), .q_o(s_ncs));

  logic                sclk_q;
  rx_state_e           state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   shift_q;
  logic                done_q;
  logic [DATA_W:0]     done_byte_q;
  logic                frame_err_q;
  logic                ovf_q;

  logic                rise, last;
  logic [DATA_W-1:0]   shifted;
  logic [CNT_W-1:0]    cnt_d;

  assign rise    = s_sclk & ~sclk_q;
  assign last    = rise && (cnt_q == CNT_LAST);
  assign shifted = {shift_q[DATA_W-2:0], s_sdin};
  assign cnt_d   = last ? '0 : (rise ? cnt_q + CNT_W'(1) : cnt_q);

  // A rise in the same cycle as nCS release is consumed before the release is judged.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sclk_q      <= 1'b0;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      done_q      <= 1'b0;
      done_byte_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      sclk_q      <= s_sclk;
      done_q      <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (!s_ncs) state_q <= RX_SHIFT;
        end
        RX_SHIFT: begin
          if (rise) shift_q <= shifted;
          cnt_q <= cnt_d;
          if (last) begin
            done_q      <= 1'b1;
            done_byte_q <= {s_dnc, shifted};
          end
          if (s_ncs) begin
            state_q     <= RX_IDLE;
            frame_err_q <= (cnt_d != '0);
          end
        end
      endcase
    end
  end

  logic pop, push, full, ovf_set;
  assign pop     = RxValid && RxReady;
  assign push    = done_q && (!full || pop);
  assign ovf_set = done_q && full && !pop;

`ifdef SPI_DISPLAY_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W:0] mem_q [FIFO_DEPTH];
  logic [AW:0]     wr_q, rd_q;

  assign full                = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign RxValid             = (wr_q != rd_q);
  assign {RxIsData, RxData}  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q[AW-1:0]] <= done_byte_q;
        wr_q                <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end
`else
  logic [DATA_W:0] hold_q;
  logic            valid_q;

  assign full               = valid_q;
  assign RxValid            = valid_q;
  assign {RxIsData, RxData} = hold_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else if (push) begin
      hold_q  <= done_byte_q;
      valid_q <= 1'b1;
    end else if (pop) begin
      valid_q <= 1'b0;
    end
  end
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)            ovf_q <= 1'b0;
    else if (ovf_set)     ovf_q <= 1'b1;
    else if (ClearStatus) ovf_q <= 1'b0;
  end

  assign Overflow   = ovf_q;
  assign FrameError = frame_err_q;
  assign Busy       = (state_q == RX_SHIFT);
endmodule

// File: tb/tb_spi_display_rx.sv
// tb/tb_spi_display_rx.sv - scoreboard bench for spi_display_rx
module tb_spi_display_rx;
  localparam int S = 2;
`ifdef SPI_DISPLAY_RX_FIFO_EN
  localparam int NOVF = 5;
`else
  localparam int NOVF = 2;
`endif

  logic       Clock = 0, Reset = 1, SCLK = 0, SDIN = 0, DnC = 0, nCS = 1;
  logic       RxReady = 0, ClearStatus = 0;
  logic [7:0] RxData;
  logic       RxIsData, RxValid, Overflow, FrameError, Busy;

  spi_display_rx #(.SYNC_STAGES(S), .DATA_W(8), .FIFO_DEPTH(4)) dut (
    .Clock(Clock), .Reset(Reset), .SCLK(SCLK), .SDIN(SDIN), .DnC(DnC), .nCS(nCS),
    .RxData(RxData), .RxIsData(RxIsData), .RxValid(RxValid), .RxReady(RxReady),
    .ClearStatus(ClearStatus), .Overflow(Overflow), .FrameError(FrameError), .Busy(Busy));

  always #5 Clock = ~Clock;

  int         checks = 0, passed = 0;
  int         fe_cnt = 0, fe_long = 0;
  logic       fe_prev = 0;
  logic [8:0] exp_q[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every accepted byte and tracks FrameError pulses.
  always @(negedge Clock) begin
    logic [8:0] e;
    if (Reset) begin
      fe_prev = 1'b0;
    end else begin
      if (FrameError) begin
        fe_cnt++;
        if (fe_prev) fe_long++;
      end
      fe_prev = FrameError;
      if (RxValid && RxReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_byte: got %0h expected none", {RxIsData, RxData});
        end else begin
          e = exp_q.pop_front();
          check("rx_byte", {RxIsData, RxData}, e);
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge Clock); #2; end
  endtask

  task automatic send_bit(logic b);
    SDIN = b; tick(3); SCLK = 1; tick(3); SCLK = 0;
  endtask

  task automatic send_byte(logic [7:0] d, logic dc);
    DnC = dc;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    tick(2);
  endtask

  initial begin
    int         n, fe_before;
    logic [7:0] d;
    logic [7:0] ovf_bytes [5];
    ovf_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    #1;
    check("reset_outputs", {RxValid, RxIsData, RxData, Overflow, FrameError, Busy}, 0);
    tick(3); Reset = 0; nCS = 0; tick(4);

    // Command byte 0xAE with latency measured from the 8th pin rise
    RxReady = 0; DnC = 0; d = 8'hAE;
    exp_q.push_back({1'b0, 8'hAE});
    for (int i = 7; i >= 1; i--) send_bit(d[i]);
    SDIN = d[0]; tick(3); SCLK = 1;
    n = 0;
    while (!RxValid && n < 20) begin @(posedge Clock); n++; #2; end
    check("latency", n, S + 2);
    SCLK = 0; tick(3);
    check("hold_valid", RxValid, 1);
    check("hold_data", {RxIsData, RxData}, {1'b0, 8'hAE});
    RxReady = 1; tick(2);
    check("valid_drop", RxValid, 0);

    // Back-to-back data bytes
    exp_q.push_back({1'b1, 8'hA5});
    exp_q.push_back({1'b1, 8'h3C});
    send_byte(8'hA5, 1); send_byte(8'h3C, 1); tick(6);
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_no_ovf", Overflow, 0);

    // Aborted frame after 5 bits
    fe_before = fe_cnt; DnC = 0;
    repeat (5) send_bit(1'b1);
    nCS = 1; tick(8);
    check("frame_err_pulse", fe_cnt, fe_before + 1);
    check("idle_after_abort", Busy, 0);
    nCS = 0; tick(4);
    exp_q.push_back({1'b0, 8'h81});
    send_byte(8'h81, 0); tick(6);
    check("after_abort_drained", exp_q.size(), 0);

    // Overflow with consumer stalled
    RxReady = 0;
    for (int i = 0; i < NOVF - 1; i++) exp_q.push_back({1'b1, ovf_bytes[i]});
    for (int i = 0; i < NOVF; i++) send_byte(ovf_bytes[i], 1);
    tick(4);
    check("ovf_set", Overflow, 1);
    check("ovf_head", {RxValid, RxIsData, RxData}, {2'b11, 8'h11});
    RxReady = 1; tick(NOVF + 4);
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_sticky", Overflow, 1);
    ClearStatus = 1; tick(1); ClearStatus = 0;
    check("ovf_clear", Overflow, 0);

    // 8th rise coincident with nCS release
    fe_before = fe_cnt; DnC = 1; d = 8'h55;
    exp_q.push_back({1'b1, 8'h55});
    for (int i = 7; i >= 1; i--) send_bit(d[i]);
    SDIN = d[0]; tick(3); SCLK = 1; nCS = 1; tick(3); SCLK = 0; tick(8);
    check("coincident_no_fe", fe_cnt, fe_before);
    check("coincident_drained", exp_q.size(), 0);
    nCS = 0; tick(4);

    // Reset mid-byte with a byte pending
    RxReady = 0;
    send_byte(8'h99, 1); tick(4);
    repeat (4) send_bit(1'b1);
    check("busy_mid_byte", {RxValid, Busy}, 2'b11);
    Reset = 1; #1;
    check("reset_mid_byte", {RxValid, RxIsData, RxData, Overflow, FrameError, Busy}, 0);
    tick(3); Reset = 0; tick(4);
    RxReady = 1;
    exp_q.push_back({1'b1, 8'h0F});
    send_byte(8'h0F, 1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin tick(1); n++; end
    check("final_drained", exp_q.size(), 0);
    check("fe_total", fe_cnt, 1);
    check("fe_single_cycle", fe_long, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
